// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM for the CALC accumulator datapath (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define CALC_STEP_EN to add the single-step Step input that gates FETCH.
module controle_multiciclo #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
`ifdef CALC_STEP_EN
    input  logic             Step,
`endif
    input  logic [2:0]       OpCode,
    output logic             IREsc,
    output logic             PCEsc,
    output logic             MemEn,
    output logic             MemOp,
    output logic             RegEsc,
    output logic             FonteEscrita,
    output logic             MemtoReg,
    output logic [3:0]       ALUCode,
    output logic             Clear,
    output logic             Stop,
    output logic [2:0]       Estado,
    output logic [CNT_W-1:0] NumInstr
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } estado_t;

    localparam logic [2:0] OpLoad  = 3'b100;
    localparam logic [2:0] OpStore = 3'b101;
    localparam logic [2:0] OpClr   = 3'b110;
    localparam logic [2:0] OpHalt  = 3'b111;
    localparam logic [3:0] MemWaitInit = 4'(MEM_WAIT);

    estado_t          state, nextState;
    logic [2:0]       opR, opRNext;
    logic [3:0]       waitCnt, waitNext;
    logic [CNT_W-1:0] numInstrQ;
    logic             retire;
    logic             fetchGo;

`ifdef CALC_STEP_EN
    assign fetchGo = Step;
`else
    assign fetchGo = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= StFetch;
            opR       <= 3'b000;
            waitCnt   <= 4'd0;
            numInstrQ <= '0;
        end else begin
            state   <= nextState;
            opR     <= opRNext;
            waitCnt <= waitNext;
            if (retire) begin
                numInstrQ <= numInstrQ + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nextState    = state;
        opRNext      = opR;
        waitNext     = waitCnt;
        retire       = 1'b0;
        IREsc        = 1'b0;
        PCEsc        = 1'b0;
        MemEn        = 1'b0;
        MemOp        = 1'b0;
        RegEsc       = 1'b0;
        FonteEscrita = 1'b0;
        MemtoReg     = 1'b0;
        ALUCode      = 4'b0000;
        Clear        = 1'b0;
        Stop         = 1'b0;

        case (state)
            StFetch: begin
                if (fetchGo) begin
                    IREsc     = 1'b1;
                    PCEsc     = 1'b1;
                    nextState = StDecode;
                end
            end
            StDecode: begin
                opRNext = OpCode;
                if (!OpCode[2]) begin
                    nextState = StExec;
                end else if (OpCode == OpHalt) begin
                    nextState = StHalt;
                    retire    = 1'b1;
                end else begin
                    nextState = StMem;
                    waitNext  = MemWaitInit;
                end
            end
            StExec: begin
                ALUCode   = {2'b00, opR[1:0]};
                nextState = StWb;
            end
            StMem: begin
                MemEn = (opR != OpClr);
                MemOp = (opR == OpStore);
                Clear = (opR == OpClr);
                // Exit on the cycle the counter reads zero: MEM lasts MEM_WAIT+1 cycles.
                if (waitCnt == 4'd0) begin
                    if (opR == OpLoad) begin
                        nextState = StWb;
                    end else begin
                        nextState = StFetch;
                        retire    = 1'b1;
                    end
                end else begin
                    waitNext = waitCnt - 4'd1;
                end
            end
            StWb: begin
                RegEsc = 1'b1;
                if (!opR[2]) begin
                    ALUCode = {2'b00, opR[1:0]};
                end else begin
                    FonteEscrita = 1'b1;
                    MemtoReg     = 1'b1;
                end
                nextState = StFetch;
                retire    = 1'b1;
            end
            StHalt: begin
                Stop = 1'b1;
            end
            default: begin
                nextState = StFetch;
            end
        endcase

        // Reset masks every strobe combinationally, not just from the next edge.
        if (Reset) begin
            IREsc        = 1'b0;
            PCEsc        = 1'b0;
            MemEn        = 1'b0;
            MemOp        = 1'b0;
            RegEsc       = 1'b0;
            FonteEscrita = 1'b0;
            MemtoReg     = 1'b0;
            ALUCode      = 4'b0000;
            Clear        = 1'b0;
            Stop         = 1'b0;
        end
    end

    assign Estado   = Reset ? 3'd0 : state;
    assign NumInstr = numInstrQ;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: an instruction-level model expands each random
// opcode into its expected per-cycle outputs; a negedge monitor pops and compares.
module tb_controle_multiciclo;

    localparam int unsigned MEM_WAIT  = 2;
    localparam int unsigned CNT_W     = 4;
    localparam int          NUM_INSTR = 300;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [2:0]       OpCode = 3'b000;
`ifdef CALC_STEP_EN
    logic             Step = 1'b0;
    localparam bit    STEP_EN = 1'b1;
`else
    localparam bit    STEP_EN = 1'b0;
`endif
    logic             IREsc, PCEsc, MemEn, MemOp, RegEsc, FonteEscrita, MemtoReg, Clear, Stop;
    logic [3:0]       ALUCode;
    logic [2:0]       Estado;
    logic [CNT_W-1:0] NumInstr;

    typedef struct packed {
        logic [2:0] estado;
        logic       ire;
        logic       pc;
        logic       memEn;
        logic       memOp;
        logic       regEsc;
        logic       fonte;
        logic       m2r;
        logic [3:0] alu;
        logic       clr;
        logic       stop;
    } outs_t;

    typedef struct packed {
        outs_t            o;
        logic [CNT_W-1:0] num;
        logic             chkNum;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic step;
        logic dec;
    } cyc_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    controle_multiciclo #(
        .MEM_WAIT(MEM_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
`ifdef CALC_STEP_EN
        .Step        (Step),
`endif
        .OpCode      (OpCode),
        .IREsc       (IREsc),
        .PCEsc       (PCEsc),
        .MemEn       (MemEn),
        .MemOp       (MemOp),
        .RegEsc      (RegEsc),
        .FonteEscrita(FonteEscrita),
        .MemtoReg    (MemtoReg),
        .ALUCode     (ALUCode),
        .Clear       (Clear),
        .Stop        (Stop),
        .Estado      (Estado),
        .NumInstr    (NumInstr)
    );

    function automatic outs_t mk(input logic [2:0] est);
        outs_t o;
        o = '0;
        o.estado = est;
        return o;
    endfunction

    task automatic drive(input cyc_t c, input logic rst, input logic [2:0] op);
        @(posedge Clk);
        #1;
        Reset  = rst;
        OpCode = op;
`ifdef CALC_STEP_EN
        Step = c.step;
`endif
        expQ.push_back(c.e);
    endtask

    // Monitor: one expected entry per clock cycle.
    initial begin
        exp_t  e;
        outs_t act;
        forever begin
            @(negedge Clk);
            if (expQ.size() != 0) begin
                e   = expQ.pop_front();
                act = {Estado, IREsc, PCEsc, MemEn, MemOp, RegEsc, FonteEscrita, MemtoReg,
                       ALUCode, Clear, Stop};
                checks++;
                if (act !== e.o) begin
                    errors++;
                    $display("FAIL outputs t=%0t {Estado,IR,PC,MemEn,MemOp,RegEsc,Fonte,M2R,ALU,Clr,Stop} got %b required %b",
                             $time, act, e.o);
                end
                if (e.chkNum) begin
                    checks++;
                    if (NumInstr !== e.num) begin
                        errors++;
                        $display("FAIL NumInstr t=%0t got %0d required %0d", $time, NumInstr, e.num);
                    end
                end
            end
        end
    end

    initial begin
        cyc_t             seq[$];
        cyc_t             c;
        cyc_t             rc;
        logic [2:0]       op;
        logic [CNT_W-1:0] cnt;
        int               decIdx, memIdx, rstAt, idle;
        bit               aborted;

        rc        = '0;
        rc.e.o    = mk(3'd0);
        cnt       = '0;
        repeat (3) drive(rc, 1'b1, 3'($urandom));

        for (int n = 0; n < NUM_INSTR; n++) begin
            if (n == 0)      op = 3'b101;
            else if (n == 1) op = 3'b000;
            else if (n == 2) op = 3'b100;
            else if (n == 3) op = 3'b101;
            else if (n == 4) op = 3'b110;
            else if (n == 5) op = 3'b111;
            else if (n < 26) op = 3'($urandom_range(0, 6));
            else begin
                op = 3'($urandom);
                if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 3));
            end

            seq.delete();
            idle = STEP_EN ? ((n == 1) ? 10 : int'($urandom_range(0, 2))) : 0;
            for (int i = 0; i < idle; i++) begin
                c = '0;
                c.e.o = mk(3'd0);
                c.e.num = cnt;
                c.e.chkNum = 1'b1;
                seq.push_back(c);
            end
            c = '0;
            c.e.o = mk(3'd0);
            c.e.o.ire = 1'b1;
            c.e.o.pc = 1'b1;
            c.e.num = cnt;
            c.e.chkNum = 1'b1;
            c.step = 1'b1;
            seq.push_back(c);

            decIdx = seq.size();
            c = '0;
            c.e.o = mk(3'd1);
            c.e.num = cnt;
            c.e.chkNum = 1'b1;
            c.step = 1'($urandom);
            c.dec = 1'b1;
            seq.push_back(c);
            memIdx = seq.size();

            c.dec = 1'b0;
            if (!op[2]) begin
                c.e.o = mk(3'd2);
                c.e.o.alu = {1'b0, op};
                seq.push_back(c);
                c.e.o = mk(3'd4);
                c.e.o.alu = {1'b0, op};
                c.e.o.regEsc = 1'b1;
                seq.push_back(c);
            end else if (op != 3'b111) begin
                for (int i = 0; i <= int'(MEM_WAIT); i++) begin
                    c.e.o = mk(3'd3);
                    c.e.o.memEn = (op != 3'b110);
                    c.e.o.memOp = (op == 3'b101);
                    c.e.o.clr = (op == 3'b110);
                    c.step = 1'($urandom);
                    seq.push_back(c);
                end
                if (op == 3'b100) begin
                    c.e.o = mk(3'd4);
                    c.e.o.regEsc = 1'b1;
                    c.e.o.fonte = 1'b1;
                    c.e.o.m2r = 1'b1;
                    seq.push_back(c);
                end
            end else begin
                c.e.num = cnt + CNT_W'(1);
                for (int i = 0; i < 22 + int'($urandom_range(0, 4)); i++) begin
                    c.e.o = mk(3'd5);
                    c.e.o.stop = 1'b1;
                    c.step = 1'($urandom);
                    seq.push_back(c);
                end
            end

            rstAt = -1;
            if (n == 0) rstAt = memIdx + 1;
            else if (n >= 26 && $urandom_range(0, 24) == 0)
                rstAt = int'($urandom_range(0, seq.size() - 1));

            aborted = 1'b0;
            for (int i = 0; i < seq.size(); i++) begin
                if (i == rstAt) begin
                    drive(rc, 1'b1, 3'($urandom));
                    cnt = '0;
                    aborted = 1'b1;
                    break;
                end
                drive(seq[i], 1'b0, (i == decIdx) ? op : 3'($urandom));
            end
            if (!aborted) begin
                if (op == 3'b111) begin
                    drive(rc, 1'b1, 3'($urandom));
                    cnt = '0;
                end else begin
                    cnt = cnt + CNT_W'(1);
                end
            end
        end

        repeat (3) @(posedge Clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending entries required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
